fifo_sync_param: RTL
====================

// Module: fifo_sync_param
// PURPOSE
//   Parametrised single-clock FIFO; successor to the fixed 16x8 FIFO. Adds occupancy count,
//   programmable almost-full/almost-empty flags, synchronous flush, and a selectable
//   first-word-fall-through (FWFT) read mode. Sits between a producer and a consumer in the same
//   clock domain. Storage is a register array.
// PARAMETERS
//   WIDTH      8    data width in bits, >=1
//   DEPTH      16   entries; power of two, >=2
//   AF_THRESH  12   almost_full_o asserts when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  4    almost_empty_o asserts when count <= AE_THRESH (0..DEPTH-1)
//   FWFT       0    0 = standard registered read; 1 = first-word-fall-through
//   PTR_WIDTH  $clog2(DEPTH)   derived; not to be overridden
// PORTS
//   clk_i           in   1            clock, rising edge
//   rst_ni          in   1            asynchronous active-low reset
//   flush_i         in   1            synchronous clear of all contents
//   wr_en_i         in   1            write request
//   wdata_i         in   WIDTH        write data
//   rd_en_i         in   1            read request (pop)
//   rdata_o         out  WIDTH        read data
//   rd_valid_o      out  1            rdata_o valid (meaning depends on FWFT)
//   full_o          out  1            count == DEPTH
//   empty_o         out  1            count == 0
//   almost_full_o   out  1            count >= AF_THRESH
//   almost_empty_o  out  1            count <= AE_THRESH
//   count_o         out  PTR_WIDTH+1  current occupancy, 0..DEPTH
//   wr_error_o      out  1            1-cycle pulse: write rejected
//   rd_error_o      out  1            1-cycle pulse: read rejected
// BEHAVIOUR
// - Pointers are PTR_WIDTH+1 bits (MSB = wrap toggle). Empty: ptrs equal. Full: low bits equal and
//   MSBs differ. count_o = wr_ptr - rd_ptr, modulo 2^(PTR_WIDTH+1).
// - Reset (rst_ni=0, async): ptrs=0, count_o=0, empty_o=1, almost_empty_o=1, full_o=0,
//   almost_full_o=(AF_THRESH==0 ? 1 : 0), rdata_o=0, rd_valid_o=0, wr_error_o=0, rd_error_o=0.
//   Memory contents are not reset. Reset mid-operation discards all data.
// - Write accepted iff wr_en_i && (!full_o || rd_accept). Data is stored at wr_ptr; wr_ptr++ at
//   the edge.
// - Read accepted (rd_accept) iff rd_en_i && !empty_o. A write in the same cycle never makes an
//   empty FIFO readable; the read is rejected.
// - Full + wr_en_i + rd_en_i: both accepted, count unchanged.
// - Empty + wr_en_i + rd_en_i: write accepted, read rejected, rd_error_o pulses.
// - Rejected write (full, no read): data dropped, ptrs unchanged, wr_error_o=1 next cycle for
//   one cycle.
// - Rejected read (empty): ptrs unchanged, rd_error_o=1 next cycle for one cycle.
// - FWFT=0: on an accepted read, rdata_o <= mem[rd_ptr] and rd_valid_o=1 next cycle. rdata_o
//   holds its value otherwise. rd_valid_o is a 1-cycle pulse per accepted read.
//   Latency: write to readable = 1 cycle; read request to data = 1 cycle.
// - FWFT=1: rdata_o = mem[rd_ptr] (combinational) and rd_valid_o = !empty_o. rd_en_i acknowledges
//   the shown word. Latency: write to rd_valid_o = 1 cycle.
// - Flags and count_o are registered, or derived from registered ptrs only; all update at the
//   edge following the causing access.
// - flush_i=1: at the edge, ptrs=0 and rd_valid_o=0. Flush has priority over same-cycle
//   wr/rd: no data stored, no error pulses. rdata_o holds its value.
// - No internal state machine beyond the pointers. Behaviour under X on enables is undefined.
// TESTING
// 1 Reset: rst_ni low for 2 cycles mid-stream -> empty_o=1, count_o=0, full_o=0, no error pulses.
// 2 Fill: write 16 words 0x01..0x10 -> almost_full_o rises after 12th write, full_o after 16th.
//   A 17th write gives wr_error_o pulse and count_o stays 16.
// 3 Drain, FWFT=0: 16 reads -> rdata_o sequence 0x01..0x10, each 1 cycle after rd_en_i,
//   rd_valid_o pulses 16 times. A 17th read gives rd_error_o pulse. almost_empty_o rises at
//   count_o=4.
// 4 Simultaneous ops: at full, wr+rd in the same cycle -> count_o stays 16 and no error.
//   At empty, wr+rd -> count_o=1 and rd_error_o pulses.
// 5 Wrap: 3 passes of write-10/read-10 (ptr wrap) -> data order preserved and count_o returns to 0.
// 6 FWFT=1 and flush: write 0xA5 -> rdata_o=0xA5 and rd_valid_o=1 one cycle later.
//   flush_i with wr_en_i -> count_o=0, empty_o=1, no error pulse.

Source files
------------

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with count, programmable flags, flush and FWFT mode
module fifo_sync_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0,
    localparam int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               wr_en_i,
    input  logic [WIDTH-1:0]   wdata_i,
    input  logic               rd_en_i,
    output logic [WIDTH-1:0]   rdata_o,
    output logic               rd_valid_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               almost_full_o,
    output logic               almost_empty_o,
    output logic [PTR_WIDTH:0] count_o,
    output logic               wr_error_o,
    output logic               rd_error_o
);
    localparam logic [PTR_WIDTH:0] AF_T = (PTR_WIDTH+1)'(AF_THRESH);
    localparam logic [PTR_WIDTH:0] AE_T = (PTR_WIDTH+1)'(AE_THRESH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_WIDTH:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0]   rdata_q;
    logic               rd_valid_q;
    logic               rd_accept, wr_accept;

    // flags and occupancy come straight from the registered pointers
    assign count_o        = wr_ptr - rd_ptr;
    assign empty_o        = wr_ptr == rd_ptr;
    assign full_o         = (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]) && (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]);
    assign almost_full_o  = count_o >= AF_T;
    assign almost_empty_o = count_o <= AE_T;

    // a same-cycle read frees a slot for the write, but a write never makes an empty FIFO readable
    assign rd_accept = rd_en_i && !empty_o;
    assign wr_accept = wr_en_i && (!full_o || rd_accept);

    // FWFT shows the head word directly; zero while empty so the output is defined after reset
    assign rdata_o    = (FWFT != 0) ? (empty_o ? '0 : mem[rd_ptr[PTR_WIDTH-1:0]]) : rdata_q;
    assign rd_valid_o = (FWFT != 0) ? !empty_o : rd_valid_q;

    // storage array, deliberately not reset
    always_ff @(posedge clk_i) begin
        if (wr_accept && !flush_i) mem[wr_ptr[PTR_WIDTH-1:0]] <= wdata_i;
    end

    // pointers, registered read port and error pulses; flush overrides any same-cycle access
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            wr_error_o <= 1'b0;
            rd_error_o <= 1'b0;
        end else if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_valid_q <= 1'b0;
            wr_error_o <= 1'b0;
            rd_error_o <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + (PTR_WIDTH+1)'(wr_accept);
            rd_ptr     <= rd_ptr + (PTR_WIDTH+1)'(rd_accept);
            rdata_q    <= rd_accept ? mem[rd_ptr[PTR_WIDTH-1:0]] : rdata_q;
            rd_valid_q <= rd_accept;
            wr_error_o <= wr_en_i && !wr_accept;
            rd_error_o <= rd_en_i && empty_o;
        end
    end
endmodule
